// File: rtl/id_stage.sv
// Decode stage: IF/ID register, bypassed register file, immediate generation,
// control decode, early branch/JAL resolution and the registered ID/EX boundary.
module id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     instruction_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            PCSrc,
  output logic [XLEN-1:0] imm_ext,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [1:0]      ex_wb_sel,
  output logic            ex_illegal
);
  localparam logic [6:0]  OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                          OP_IMM = 7'b0010011, OP_OP = 7'b0110011;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  // IF/ID state
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  logic [XLEN-1:0] regs [32];

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  assign imm_i = XLEN'($signed(if_instr[31:20]));
  assign imm_s = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
  assign imm_b = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({if_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0}));

  // funct3 -> ALU op; alt selects SUB/SRA via instr[30]
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_f3 = ALU_SLL;
      3'd2:    alu_f3 = ALU_SLT;
      3'd3:    alu_f3 = ALU_SLTU;
      3'd4:    alu_f3 = ALU_XOR;
      3'd5:    alu_f3 = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction

  ctrl_t ctrl;
  // Control decode and immediate format select
  always_comb begin
    ctrl = '0;
    imm  = '0;
    case (opcode)
      OP_LUI:    begin imm = imm_u; ctrl.alu_op = ALU_PASS_B; ctrl.alu_src_imm = 1'b1; ctrl.reg_write = 1'b1; end
      OP_AUIPC:  begin imm = imm_u; ctrl.alu_op = ALU_ADD; ctrl.alu_src_imm = 1'b1; ctrl.reg_write = 1'b1; end
      OP_JAL:    begin imm = imm_j; ctrl.reg_write = 1'b1; ctrl.wb_sel = 2'd2; end
      OP_BRANCH: begin imm = imm_b; ctrl.alu_op = ALU_SUB; end
      OP_LOAD:   begin imm = imm_i; ctrl.alu_src_imm = 1'b1; ctrl.reg_write = 1'b1;
                       ctrl.mem_read = 1'b1; ctrl.wb_sel = 2'd1; end
      OP_STORE:  begin imm = imm_s; ctrl.alu_src_imm = 1'b1; ctrl.mem_write = 1'b1; end
      OP_IMM:    begin imm = imm_i; ctrl.alu_op = alu_f3(funct3, (funct3 == 3'd5) && if_instr[30]);
                       ctrl.alu_src_imm = 1'b1; ctrl.reg_write = 1'b1; end
      OP_OP:     begin ctrl.alu_op = alu_f3(funct3, ((funct3 == 3'd0) || (funct3 == 3'd5)) && if_instr[30]);
                       ctrl.reg_write = 1'b1; end
      default:   ctrl.illegal = 1'b1;
    endcase
  end

  // Operand read with same-cycle write-back bypass; x0 hardwired to zero
  logic [XLEN-1:0] rs1_data, rs2_data;
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0) rs1_data = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != 5'd0) rs2_data = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

  // Branch condition on bypassed operands
  logic cond, taken;
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'd0:    cond = (rs1_data == rs2_data);
      3'd1:    cond = (rs1_data != rs2_data);
      3'd4:    cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'd5:    cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'd6:    cond = (rs1_data <  rs2_data);
      3'd7:    cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  assign taken   = if_valid && !stall && !flush &&
                   ((opcode == OP_JAL) || ((opcode == OP_BRANCH) && cond));
  // Fetch already points at id_pc+4, so the offset is pre-biased by -4
  assign PCSrc   = taken;
  assign imm_ext = taken ? (imm - XLEN'(4)) : '0;

  // IF/ID register: squash beats hold beats capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_instr <= NOP;
    end else if (flush || taken) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_valid <= 1'b1;
      if_pc    <= pc_in;
      if_instr <= instruction_in;
    end
  end

  // Register file write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  ctrl_t ex_ctrl;
  // ID/EX register: data fields always load, control is zeroed on a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_ctrl     <= '0;
    end else begin
      ex_pc       <= if_pc;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= imm;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rd       <= rd;
      ex_funct3   <= funct3;
      if (stall || !if_valid || flush) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= ctrl;
      end
    end
  end

  assign ex_alu_op      = ex_ctrl.alu_op;
  assign ex_alu_src_imm = ex_ctrl.alu_src_imm;
  assign ex_reg_write   = ex_ctrl.reg_write;
  assign ex_mem_read    = ex_ctrl.mem_read;
  assign ex_mem_write   = ex_ctrl.mem_write;
  assign ex_wb_sel      = ex_ctrl.wb_sel;
  assign ex_illegal     = ex_ctrl.illegal;
endmodule
